// File: rtl/io_uart_in_pkg.sv
// rtl/io_uart_in_pkg.sv - IO address map and RX status layout shared by the io_* peripherals
package io_uart_in_pkg;

  localparam logic [13:0] ADR_RXDATA_DEF = 14'h3E10;
  localparam logic [13:0] ADR_RXSTAT_DEF = 14'h3E11;

  localparam int RXSTAT_IE_BIT    = 18;
  localparam int RXSTAT_FULL_BIT  = 17;
  localparam int RXSTAT_EMPTY_BIT = 16;
  localparam int RXSTAT_OVF_BIT   = 8;
  localparam int RXDATA_VALID_BIT = 8;

  function automatic logic [31:0] rxstat_pack(input logic ie, input logic full,
                                              input logic empty, input logic ovf,
                                              input logic [7:0] count);
    logic [31:0] v;
    v = {24'd0, count};
    v[RXSTAT_IE_BIT]    = ie;
    v[RXSTAT_FULL_BIT]  = full;
    v[RXSTAT_EMPTY_BIT] = empty;
    v[RXSTAT_OVF_BIT]   = ovf;
    return v;
  endfunction

  function automatic logic [31:0] rxdata_pack(input logic valid, input logic [7:0] char_in);
    logic [31:0] v;
    v = 32'd0;
    if (valid) begin
      v[7:0]              = char_in;
      v[RXDATA_VALID_BIT] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/io_uart_in_if.sv
// rtl/io_uart_in_if.sv - dma_io bus bundle including the rdata daisy-chain in/out
interface io_uart_in_if;

  logic        we;
  logic [13:0] wadr;
  logic [31:0] wdata;
  logic [13:0] radr;
  logic        radr_en;
  logic [31:0] rdata_in;
  logic [31:0] rdata;

  modport master (
    output we, wadr, wdata, radr, radr_en, rdata_in,
    input  rdata
  );

  modport slave (
    input  we, wadr, wdata, radr, radr_en, rdata_in,
    output rdata
  );

endinterface

// File: rtl/io_uart_in_fifo.sv
// rtl/io_uart_in_fifo.sv - synchronous byte FIFO with wrap pointers; caller qualifies push/pop
module io_uart_in_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [7:0]          push_data,
  input  logic                pop,
  output logic [7:0]          head_data,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty,
  output logic                full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == (DEPTH_LOG2+1)'(DEPTH));

endmodule

// File: rtl/io_uart_in.sv
// rtl/io_uart_in.sv - console UART receive peripheral: FIFO, RXDATA/RXSTAT registers, rdata chain stage
module io_uart_in
  import io_uart_in_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [13:0] ADR_RXDATA = ADR_RXDATA_DEF,
  parameter logic [13:0] ADR_RXSTAT = ADR_RXSTAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  io_uart_in_if.slave  bus,
  input  logic [7:0]   uart_rx_char,
  input  logic         uart_rx_we,
  output logic         rx_irq
);

  logic                rd_rxdata;
  logic                rd_rxstat;
  logic                wr_rxstat;
  logic                pop;
  logic                push;
  logic                drop;
  logic [7:0]          head_data;
  logic [DEPTH_LOG2:0] count;
  logic                empty;
  logic                full;
  logic                rx_ie;
  logic                overflow;
  logic                rd_hit;
  logic [31:0]         rd_data;
  logic [31:0]         rd_value;
  logic                unused_wdata;

  assign rd_rxdata = bus.radr_en && (bus.radr == ADR_RXDATA);
  assign rd_rxstat = bus.radr_en && (bus.radr == ADR_RXSTAT);
  assign wr_rxstat = bus.we && (bus.wadr == ADR_RXSTAT);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  assign pop  = rd_rxdata && !empty;
  assign push = uart_rx_we && (!full || pop);
  assign drop = uart_rx_we && full && !pop;

  io_uart_in_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (uart_rx_char),
    .pop       (pop),
    .head_data (head_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always_comb begin
    rd_value = 32'd0;
    if (rd_rxdata)
      rd_value = rxdata_pack(!empty, head_data);
    else if (rd_rxstat)
      rd_value = rxstat_pack(rx_ie, full, empty, overflow, 8'(count));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_hit   <= 1'b0;
      rd_data  <= 32'd0;
      rx_ie    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_hit  <= rd_rxdata || rd_rxstat;
      rd_data <= rd_value;
      if (wr_rxstat) rx_ie <= bus.wdata[RXSTAT_IE_BIT];
      // A drop in the same cycle as the clear keeps overflow set
      if (drop)
        overflow <= 1'b1;
      else if (wr_rxstat && bus.wdata[RXSTAT_OVF_BIT])
        overflow <= 1'b0;
    end
  end

  assign bus.rdata = rd_hit ? rd_data : bus.rdata_in;
  assign rx_irq    = rx_ie && !empty;

  assign unused_wdata = ^{bus.wdata[31:19], bus.wdata[17:9], bus.wdata[7:0]};

endmodule

// File: tb/tb_io_uart_in.sv
// tb/tb_io_uart_in.sv - directed self-checking bench for io_uart_in
module tb_io_uart_in;

  localparam logic [13:0] A_DATA  = 14'h3E10;
  localparam logic [13:0] A_STAT  = 14'h3E11;
  localparam logic [13:0] A_OTHER = 14'h0123;
  localparam logic [31:0] PASS_V  = 32'hA5A5_A5A5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] uart_rx_char = 8'd0;
  logic       uart_rx_we = 1'b0;
  logic       rx_irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  io_uart_in_if bus ();

  io_uart_in dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .uart_rx_char (uart_rx_char),
    .uart_rx_we   (uart_rx_we),
    .rx_irq       (rx_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    uart_rx_char = b;
    uart_rx_we   = 1'b1;
    tick();
    uart_rx_we   = 1'b0;
  endtask

  task automatic bus_read(input logic [13:0] a, output logic [31:0] d);
    bus.radr    = a;
    bus.radr_en = 1'b1;
    tick();
    bus.radr_en = 1'b0;
    d = bus.rdata;
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [31:0] d);
    bus.wadr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  initial begin
    bus.we       = 1'b0;
    bus.wadr     = '0;
    bus.wdata    = '0;
    bus.radr     = '0;
    bus.radr_en  = 1'b0;
    bus.rdata_in = PASS_V;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state and pass-through
    check("reset_passthru", bus.rdata, PASS_V);
    check("reset_irq", {31'd0, rx_irq}, 32'd0);
    bus_read(A_STAT, rd);
    check("reset_stat", rd, 32'h0001_0000);
    bus_read(A_OTHER, rd);
    check("other_addr_passthru", rd, PASS_V);

    // Three bytes, back-to-back reads
    push(8'h41); push(8'h42); push(8'h43);
    bus_read(A_STAT, rd);
    check("stat_count3", rd, 32'h0000_0003);
    bus.radr    = A_DATA;
    bus.radr_en = 1'b1;
    tick(); check("b2b_0", bus.rdata, 32'h0000_0141);
    tick(); check("b2b_1", bus.rdata, 32'h0000_0142);
    tick(); check("b2b_2", bus.rdata, 32'h0000_0143);
    tick(); check("b2b_empty", bus.rdata, 32'h0000_0000);
    bus.radr_en = 1'b0;
    tick();
    check("idle_passthru", bus.rdata, PASS_V);
    bus_read(A_STAT, rd);
    check("stat_count0", rd, 32'h0001_0000);

    // Overflow: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) push(8'(i));
    bus_read(A_STAT, rd);
    check("stat_full_ovf", rd, 32'h0002_0110);
    for (int i = 0; i < 16; i++) begin
      bus_read(A_DATA, rd);
      check($sformatf("drain_ovf_%0d", i), rd, 32'h100 + 32'(i));
    end
    bus_read(A_DATA, rd);
    check("byte16_lost", rd, 32'h0000_0000);
    bus_read(A_STAT, rd);
    check("stat_empty_ovf", rd, 32'h0001_0100);
    bus_write(A_STAT, 32'h0000_0100);
    bus_read(A_STAT, rd);
    check("ovf_cleared", rd, 32'h0001_0000);

    // Push into a full FIFO in the same cycle as a pop
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    uart_rx_char = 8'h55;
    uart_rx_we   = 1'b1;
    bus_read(A_DATA, rd);
    uart_rx_we   = 1'b0;
    check("full_pushpop_head", rd, 32'h0000_0120);
    bus_read(A_STAT, rd);
    check("full_pushpop_stat", rd, 32'h0002_0010);
    for (int i = 1; i < 16; i++) begin
      bus_read(A_DATA, rd);
      check($sformatf("drain_full_%0d", i), rd, 32'h120 + 32'(i));
    end
    bus_read(A_DATA, rd);
    check("drain_full_55", rd, 32'h0000_0155);

    // Write RXSTAT and read it in the same cycle: read sees pre-write value
    bus.wadr    = A_STAT;
    bus.wdata   = 32'h0004_0000;
    bus.we      = 1'b1;
    bus_read(A_STAT, rd);
    bus.we      = 1'b0;
    check("rw_same_cycle", rd, 32'h0001_0000);
    bus_read(A_STAT, rd);
    check("stat_ie", rd, 32'h0005_0000);
    check("irq_ie_empty", {31'd0, rx_irq}, 32'd0);
    push(8'h7E);
    check("irq_after_push", {31'd0, rx_irq}, 32'd1);
    bus_read(A_DATA, rd);
    check("irq_pop_data", rd, 32'h0000_017E);
    check("irq_after_pop", {31'd0, rx_irq}, 32'd0);

    // Writes to RXDATA are ignored
    bus_write(A_DATA, 32'h0000_01FF);
    bus_read(A_STAT, rd);
    check("rxdata_write_ignored", rd, 32'h0005_0000);

    // Asynchronous reset with data queued and overflow set
    for (int i = 0; i < 17; i++) push(8'h60 + 8'(i));
    for (int i = 0; i < 11; i++) bus_read(A_DATA, rd);
    bus_read(A_STAT, rd);
    check("pre_reset_stat", rd, 32'h0004_0105);
    check("pre_reset_irq", {31'd0, rx_irq}, 32'd1);
    bus.radr    = A_STAT;
    bus.radr_en = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    bus.radr_en = 1'b0;
    check("async_reset_irq", {31'd0, rx_irq}, 32'd0);
    check("async_reset_passthru", bus.rdata, PASS_V);
    tick();
    rst_n = 1'b1;
    tick();
    bus_read(A_STAT, rd);
    check("post_reset_stat", rd, 32'h0001_0000);
    push(8'h33);
    bus_read(A_DATA, rd);
    check("post_reset_data", rd, 32'h0000_0133);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
